// File: rtl/sweep_capture_ctrl_pkg.sv
// Shared types and MISR helper for the exhaustive-sweep capture controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - sequencer states IDLE / SETTLE / EMIT / DONE
//   MISR_W    - signature width
//   MISR_POLY - feedback taps (CRC-16/CCITT polynomial)
//   misr_step - one signature update with a new data word
package sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int                MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    // Shift left, fold the outgoing MSB back through the polynomial, then
    // XOR in the new data word.
    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] din
    );
        logic [MISR_W-1:0] fb;
        fb = sig[MISR_W-1] ? MISR_POLY : '0;
        return {sig[MISR_W-2:0], 1'b0} ^ fb ^ din;
    endfunction

endpackage

// File: rtl/sweep_capture_ctrl_if.sv
// Record stream from the sweep controller to its consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; master holds vec/resp stable while valid & !ready.
//
// Signals:
//   rec_valid - record valid (master)
//   rec_ready - consumer ready (slave)
//   rec_vec   - stimulus vector of the record (master)
//   rec_resp  - sampled DUT response of the record (master)
interface sweep_capture_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
) ();

    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] rec_resp;

    modport master (
        output rec_valid,
        output rec_vec,
        output rec_resp,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_vec,
        input  rec_resp,
        output rec_ready
    );

endinterface

// File: rtl/sweep_capture_ctrl_misr.sv
// 16-bit multiple-input signature register with synchronous clear.
// Latency: signature reflects data_in one cycle after enable.
// Backpressure: none; the caller gates enable with its own handshake.
//
// Ports:
//   CK, reset - clock and async active-low reset
//   clear     - zero the signature (wins over enable)
//   enable    - fold data_in into the signature this edge
//   data_in   - 16-bit data word
//   sig       - current signature
module sweep_misr16
    import sweep_ctrl_pkg::*;
(
    input  logic              CK,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [MISR_W-1:0] data_in,
    output logic [MISR_W-1:0] sig
);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= misr_step(sig, data_in);
        end
    end

endmodule

// File: rtl/sweep_capture_ctrl.sv
// Exhaustive input sweep of a benchmark DUT with one {vector,response} record per vector.
// Latency: SETTLE_CYC cycles per vector to sample, record valid the cycle after; SETTLE_CYC+1 per vector at full rate.
// Backpressure: record held stable while rec_ready is low, sweep stalls indefinitely.
//
// Ports:
//   CK, reset       - clock, async active-low reset
//   start, abort    - begin a sweep from idle / cancel a sweep in progress
//   busy, done      - sweep in progress / one-cycle completion pulse
//   dut_in, dut_out - registered stimulus to and response from the DUT
//   rec             - record stream (valid/ready, vec, resp)
//   hit_cnt         - accepted records with non-zero response
//   signature       - MISR over accepted {vec, resp} records
module sweep_capture_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 1,
    parameter int SETTLE_CYC = 1
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [N_IN-1:0]    dut_in,
    input  logic [N_OUT-1:0]   dut_out,
    sweep_capture_ctrl_if.master rec,
    output logic [N_IN:0]      hit_cnt,
    output logic [MISR_W-1:0]  signature
);

    localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]   VEC_LAST = '1;
    localparam logic [N_IN-1:0]   VEC_ONE  = N_IN'(1);

    state_t            state;
    logic [N_IN-1:0]   vec;
    logic [CNT_W-1:0]  cnt;

    logic              hs;
    logic              sweep_go;
    logic [N_IN:0]     hit_inc;
    logic [MISR_W-1:0] misr_din;

    assign hs       = (state == EMIT) && rec.rec_valid && rec.rec_ready;
    assign sweep_go = (state == IDLE) && start;
    assign hit_inc  = {{N_IN{1'b0}}, |rec.rec_resp};

    // Record packed as {vec, resp} right-aligned in the 16-bit MISR word.
    always_comb begin
        misr_din = '0;
        misr_din[N_IN+N_OUT-1:0] = {rec.rec_vec, rec.rec_resp};
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            vec           <= '0;
            cnt           <= '0;
            dut_in        <= '0;
            rec.rec_valid <= 1'b0;
            rec.rec_vec   <= '0;
            rec.rec_resp  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hit_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start beats a simultaneous abort; abort alone is a no-op here
                    if (start) begin
                        vec     <= '0;
                        dut_in  <= '0;
                        cnt     <= CNT_LOAD;
                        hit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        dut_in        <= '0;
                        rec.rec_valid <= 1'b0;
                    end else if (cnt == '0) begin
                        rec.rec_resp  <= dut_out;
                        rec.rec_vec   <= vec;
                        rec.rec_valid <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                EMIT: begin
                    // A record accepted on the abort edge still counts.
                    if (hs) begin
                        rec.rec_valid <= 1'b0;
                        hit_cnt       <= hit_cnt + hit_inc;
                    end
                    if (abort) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        dut_in        <= '0;
                        rec.rec_valid <= 1'b0;
                    end else if (hs) begin
                        if (vec == VEC_LAST) begin
                            // Terminate on the all-ones vector so vec never wraps.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec    <= vec + VEC_ONE;
                            dut_in <= vec + VEC_ONE;
                            cnt    <= CNT_LOAD;
                            state  <= SETTLE;
                        end
                    end
                end

                DONE: begin
                    // start is not looked at here; it must be reissued in IDLE
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sweep_misr16 u_misr (
        .CK      (CK),
        .reset   (reset),
        .clear   (sweep_go),
        .enable  (hs),
        .data_in (misr_din),
        .sig     (signature)
    );

endmodule

// File: tb/tb_sweep_capture_ctrl.sv
// Self-checking bench for sweep_capture_ctrl: scoreboard of expected records.
// Latency: n/a.
// Backpressure: rec_ready driven by the bench, stalled on demand.
module tb_sweep_capture_ctrl;

    logic CK = 1'b0;
    logic reset;
    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- DUT A: N_IN=4, N_OUT=1, SETTLE_CYC=1, combinational model
    logic        start_a, abort_a, busy_a, done_a;
    logic [3:0]  dut_in_a;
    logic [0:0]  dut_out_a;
    logic [4:0]  hit_a;
    logic [15:0] sig_a;
    int          mode_a = 0;
    sweep_capture_ctrl_if #(.N_IN(4), .N_OUT(1)) rec_a ();

    function automatic logic model_a(input int m, input logic [3:0] v);
        case (m)
            1:       return &v;
            2:       return ^v;
            default: return 1'b0;
        endcase
    endfunction

    always_comb dut_out_a = model_a(mode_a, dut_in_a);

    sweep_capture_ctrl #(.N_IN(4), .N_OUT(1), .SETTLE_CYC(1)) u_dut_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .rec(rec_a), .hit_cnt(hit_a), .signature(sig_a)
    );

    // ---------------- DUT B: N_IN=4, N_OUT=2, SETTLE_CYC=3, registered model
    logic        start_b, abort_b, busy_b, done_b;
    logic [3:0]  dut_in_b;
    logic [1:0]  dut_out_b;
    logic [4:0]  hit_b;
    logic [15:0] sig_b;
    sweep_capture_ctrl_if #(.N_IN(4), .N_OUT(2)) rec_b ();

    always @(posedge CK or negedge reset)
        if (!reset) dut_out_b <= 2'b00;
        else        dut_out_b <= dut_in_b[1:0];

    sweep_capture_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE_CYC(3)) u_dut_b (
        .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .rec(rec_b), .hit_cnt(hit_b), .signature(sig_b)
    );

    // ---------------- reference signature and scoreboard
    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        return n ^ d;
    endfunction

    typedef struct {
        logic [3:0] vec;
        logic [1:0] resp;
        int         cyc;
    } rec_t;

    rec_t        q_a[$], q_b[$];
    rec_t        ra, rb;
    logic [4:0]  exp_hit_a, exp_hit_b;
    logic [15:0] exp_sig_a, exp_sig_b;

    task automatic push_a(input int t, input int last, input bit timed);
        exp_hit_a = '0;
        exp_sig_a = '0;
        for (int k = 0; k <= last; k++) begin
            rec_t r;
            r.vec  = k[3:0];
            r.resp = {1'b0, model_a(mode_a, k[3:0])};
            r.cyc  = timed ? t + 2 + 2 * k : -1;
            q_a.push_back(r);
            exp_hit_a = exp_hit_a + 5'(r.resp != 2'b00);
            exp_sig_a = ref_misr(exp_sig_a, {11'b0, r.vec, r.resp[0]});
        end
    endtask

    task automatic push_b(input int t);
        exp_hit_b = '0;
        exp_sig_b = '0;
        for (int k = 0; k <= 15; k++) begin
            rec_t r;
            r.vec  = k[3:0];
            r.resp = k[1:0];
            r.cyc  = t + 4 + 4 * k;
            q_b.push_back(r);
            exp_hit_b = exp_hit_b + 5'(r.resp != 2'b00);
            exp_sig_b = ref_misr(exp_sig_b, {10'b0, r.vec, r.resp});
        end
    endtask

    always @(negedge CK) begin
        if (reset && rec_a.rec_valid && rec_a.rec_ready) begin
            chk("a_rec_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                ra = q_a.pop_front();
                chk("a_rec_vec",  32'(rec_a.rec_vec),  32'(ra.vec));
                chk("a_rec_resp", 32'(rec_a.rec_resp), 32'(ra.resp[0]));
                if (ra.cyc >= 0) chk("a_rec_cyc", cyc, ra.cyc);
            end
        end
    end

    always @(negedge CK) begin
        if (reset && rec_b.rec_valid && rec_b.rec_ready) begin
            chk("b_rec_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                rb = q_b.pop_front();
                chk("b_rec_vec",  32'(rec_b.rec_vec),  32'(rb.vec));
                chk("b_rec_resp", 32'(rec_b.rec_resp), 32'(rb.resp));
                chk("b_rec_cyc",  cyc, rb.cyc);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic go_a(input int last, input bit timed, output int t);
        @(posedge CK); #1;
        start_a = 1'b1;
        t = cyc;
        push_a(t, last, timed);
        @(posedge CK); #1;
        start_a = 1'b0;
        @(negedge CK);
        chk("a_busy_after_start", 32'(busy_a), 32'd1);
    endtask

    task automatic wait_done_a(output int dc);
        dc = -1;
        for (int i = 0; i < 300 && dc < 0; i++) begin
            @(negedge CK);
            if (done_a) dc = cyc;
        end
        if (dc < 0) chk("a_done_seen", 32'(done_a), 32'd1);
    endtask

    task automatic wait_done_b(output int dc);
        dc = -1;
        for (int i = 0; i < 300 && dc < 0; i++) begin
            @(negedge CK);
            if (done_b) dc = cyc;
        end
        if (dc < 0) chk("b_done_seen", 32'(done_b), 32'd1);
    endtask

    // Step cycles until rec A presents vector v (checked just after the edge).
    task automatic find_rec_a(input logic [3:0] v, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge CK); #1;
            if (rec_a.rec_valid && rec_a.rec_vec == v) found = 1'b1;
        end
        chk("a_find_rec", 32'(found), 32'd1);
    endtask

    // ---------------- main sequence
    int          t, dc, dseen;
    bit          found;
    logic [15:0] sig_and;

    initial begin
        reset = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; rec_a.rec_ready = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; rec_b.rec_ready = 1'b1;
        repeat (3) @(posedge CK);
        @(negedge CK);
        chk("a_rst_ctl",  32'({busy_a, done_a, rec_a.rec_valid, dut_in_a, rec_a.rec_vec, rec_a.rec_resp}), 32'd0);
        chk("a_rst_stat", 32'({hit_a, sig_a}), 32'd0);
        chk("b_rst_ctl",  32'({busy_b, done_b, rec_b.rec_valid, dut_in_b, rec_b.rec_vec, rec_b.rec_resp}), 32'd0);
        chk("b_rst_stat", 32'({hit_b, sig_b}), 32'd0);
        @(posedge CK); #1;
        reset = 1'b1;

        // Stuck-at-0 DUT, full rate; start reissued in the DONE cycle is ignored.
        mode_a = 0;
        go_a(15, 1'b1, t);
        while (cyc < t + 33) begin @(posedge CK); #1; end
        start_a = 1'b1;
        @(negedge CK);
        chk("a_s0_done_pulse", 32'(done_a), 32'd1);
        chk("a_s0_busy_done",  32'(busy_a), 32'd0);
        @(posedge CK); #1;
        start_a = 1'b0;
        @(negedge CK);
        chk("a_s0_done_single", 32'(done_a), 32'd0);
        dseen = 0;
        repeat (3) begin @(negedge CK); dseen = dseen | 32'(busy_a); end
        chk("a_start_in_done_ignored", dseen, 0);
        chk("a_s0_hit", 32'(hit_a), 32'(exp_hit_a));
        chk("a_s0_sig", 32'(sig_a), 32'(exp_sig_a));
        chk("a_s0_drained", q_a.size(), 0);

        // 4-input AND DUT.
        mode_a = 1;
        go_a(15, 1'b1, t);
        wait_done_a(dc);
        chk("a_and_done_cyc", dc, t + 33);
        chk("a_and_hit", 32'(hit_a), 32'(exp_hit_a));
        chk("a_and_sig", 32'(sig_a), 32'(exp_sig_a));
        chk("a_and_drained", q_a.size(), 0);
        sig_and = sig_a;

        // Back-pressure: five cycles of rec_ready low on vector 3.
        go_a(15, 1'b0, t);
        find_rec_a(4'd3, found);
        rec_a.rec_ready = 1'b0;
        repeat (5) begin
            @(negedge CK);
            chk("a_stall_valid",  32'(rec_a.rec_valid), 32'd1);
            chk("a_stall_vec",    32'(rec_a.rec_vec),   32'd3);
            chk("a_stall_resp",   32'(rec_a.rec_resp),  32'(model_a(mode_a, 4'd3)));
            chk("a_stall_dut_in", 32'(dut_in_a),        32'd3);
            @(posedge CK); #1;
        end
        rec_a.rec_ready = 1'b1;
        wait_done_a(dc);
        chk("a_stall_sig_same", 32'(sig_a), 32'(sig_and));
        chk("a_stall_hit", 32'(hit_a), 32'(exp_hit_a));
        chk("a_stall_drained", q_a.size(), 0);

        // Abort while vector 7 waits in EMIT.
        mode_a = 2;
        go_a(6, 1'b1, t);
        find_rec_a(4'd7, found);
        rec_a.rec_ready = 1'b0;
        abort_a = 1'b1;
        @(posedge CK); #1;
        abort_a = 1'b0;
        rec_a.rec_ready = 1'b1;
        @(negedge CK);
        chk("a_abort_busy",   32'(busy_a),          32'd0);
        chk("a_abort_valid",  32'(rec_a.rec_valid), 32'd0);
        chk("a_abort_dut_in", 32'(dut_in_a),        32'd0);
        dseen = 0;
        repeat (6) begin @(negedge CK); dseen = dseen | 32'(done_a); end
        chk("a_abort_no_done", dseen, 0);
        chk("a_abort_hit", 32'(hit_a), 32'(exp_hit_a));
        chk("a_abort_sig", 32'(sig_a), 32'(exp_sig_a));
        chk("a_abort_drained", q_a.size(), 0);

        // Reset mid-SETTLE on vector 9, then a full restart from vector 0.
        go_a(15, 1'b1, t);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge CK); #1;
            if (dut_in_a == 4'd9 && !rec_a.rec_valid) found = 1'b1;
        end
        chk("a_find_settle9", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("a_midrst_ctl",  32'({busy_a, done_a, rec_a.rec_valid, dut_in_a, rec_a.rec_vec, rec_a.rec_resp}), 32'd0);
        chk("a_midrst_stat", 32'({hit_a, sig_a}), 32'd0);
        q_a.delete();
        @(posedge CK); #1;
        @(posedge CK); #1;
        reset = 1'b1;
        dseen = 0;
        repeat (5) begin @(negedge CK); dseen = dseen | 32'(busy_a) | 32'(rec_a.rec_valid); end
        chk("a_no_self_restart", dseen, 0);
        go_a(15, 1'b1, t);
        wait_done_a(dc);
        chk("a_restart_done_cyc", dc, t + 33);
        chk("a_restart_hit", 32'(hit_a), 32'(exp_hit_a));
        chk("a_restart_sig", 32'(sig_a), 32'(exp_sig_a));
        chk("a_restart_drained", q_a.size(), 0);

        // SETTLE_CYC=3 against a one-cycle registered DUT.
        @(posedge CK); #1;
        start_b = 1'b1;
        t = cyc;
        push_b(t);
        @(posedge CK); #1;
        start_b = 1'b0;
        @(negedge CK);
        chk("b_busy_after_start", 32'(busy_b), 32'd1);
        wait_done_b(dc);
        chk("b_done_cyc", dc, t + 65);
        chk("b_hit", 32'(hit_b), 32'(exp_hit_b));
        chk("b_sig", 32'(sig_b), 32'(exp_sig_b));
        chk("b_drained", q_b.size(), 0);

        @(posedge CK); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
